spi_coef_master: RTL and testbench



---
 rtl/filter_pkg.sv | 15 +
 rtl/spi_coef_master_if.sv | 16 +
 rtl/spi_sck_gen.sv | 28 ++
 rtl/spi_coef_master.sv | 99 +++++++++
 tb/tb_spi_coef_master.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// filter_pkg: frame layout, FSM state type and coefficient table for spi_coef_master
package filter_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 12;
  localparam int FRAME_W = 24;
  localparam int WR_BIT = 23;
  localparam int ADDR_LSB = 12;
  localparam int DATA_LSB = 0;
  localparam int COEF_TAPS = 16;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam logic [COEF_TAPS-1:0][DATA_W-1:0] COEF_INIT = {
    12'hF0F, 12'hE1E, 12'hD2D, 12'hC3C, 12'hB4B, 12'hA5A, 12'h969, 12'h878,
    12'h787, 12'h696, 12'h5A5, 12'h4B4, 12'h3C3, 12'h2D2, 12'h1E1, 12'h0F0
  };
endpackage

// File: rtl/spi_coef_master_if.sv
// spi_coef_master_if: request/response handshake plus SPI pins of the coefficient master
interface spi_coef_master_if;
  import filter_pkg::*;
  logic Req_Valid, Req_Ready, Req_Write;
  logic [ADDR_W-1:0] Req_Addr;
  logic [DATA_W-1:0] Req_Data, Rsp_Data;
  logic Rsp_Valid, Busy, SCK, CS, MOSI, MISO;
  modport master(
    input Req_Valid, Req_Write, Req_Addr, Req_Data, MISO,
    output Req_Ready, Rsp_Valid, Rsp_Data, Busy, SCK, CS, MOSI
  );
  modport slave(
    output Req_Valid, Req_Write, Req_Addr, Req_Data, MISO,
    input Req_Ready, Rsp_Valid, Rsp_Data, Busy, SCK, CS, MOSI
  );
endinterface

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: CLK_DIV half-period timer producing SCK and its edge strobes
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = en && cnt == CW'(CLK_DIV - 1);
  assign rise_tick = tick && !sck;
  assign fall_tick = tick && sck;
  // half-period counter; SCK flips each time a half-period expires
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      sck <= sck ^ tick;
    end
endmodule

// File: rtl/spi_coef_master.sv
// spi_coef_master: 24-bit SPI register-port initiator; COEF_AUTOLOAD_EN adds coefficient autoload after reset
module spi_coef_master
  import filter_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 4,
  parameter int NUM_TAPS = 16
) (
  input logic Clk,
  input logic Rst,
  spi_coef_master_if.master bus
);
  localparam int GW = $clog2(CS_GAP + 1);
  state_t state, state_n;
  logic [FRAME_W-1:0] frame, req_frame, al_frame;
  logic [DATA_W-1:0] shreg, rsp_data;
  logic [4:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic wr, rsp_valid, al_active, start, cs_low, sck, rise_tick, fall_tick, last_bit, hold_done, gap_done;
`ifdef COEF_AUTOLOAD_EN
  localparam int IW = $clog2(COEF_TAPS);
  logic [IW-1:0] al_idx;
  assign al_frame = {1'b1, 3'b000, ADDR_W'(al_idx), COEF_INIT[al_idx]};
  // walk the coefficient table once after every reset, one write per frame
  always_ff @(posedge Clk)
    if (Rst) begin
      al_active <= 1'b1;
      al_idx <= '0;
    end else if (gap_done && al_active) begin
      al_active <= al_idx != IW'(NUM_TAPS - 1);
      al_idx <= al_idx + 1'b1;
    end
`else
  assign al_active = 1'b0;
  assign al_frame = '0;
`endif
  assign cs_low = state inside {SETUP, SHIFT, HOLD};
  assign last_bit = bit_cnt == 5'd23;
  assign hold_done = state == HOLD && rise_tick;
  assign gap_done = state == GAP && gap_cnt == GW'(CS_GAP - 1);
  assign start = state == IDLE && (al_active || (bus.Req_Valid && bus.Req_Ready));
  assign req_frame = {bus.Req_Write, 3'b000, bus.Req_Addr, bus.Req_Write ? bus.Req_Data : {DATA_W{1'b0}}};
  assign bus.Req_Ready = state == IDLE && !al_active && !Rst;
  assign bus.Busy = state != IDLE || al_active;
  assign bus.SCK = sck;
  assign bus.CS = !cs_low;
  assign bus.MOSI = cs_low && frame[WR_BIT];
  assign bus.Rsp_Valid = rsp_valid;
  assign bus.Rsp_Data = rsp_data;
  // the HOLD-ending tick would raise SCK, so the timer is cleared on it instead
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk(Clk),
    .rst(Rst),
    .en(cs_low),
    .clr(!cs_low || hold_done),
    .sck(sck),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );
  // state register
  always_ff @(posedge Clk)
    state <= Rst ? IDLE : state_n;
  // frame sequencing: setup, 24 SCK periods, hold, inter-frame gap
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? SETUP : IDLE;
      SETUP:   state_n = rise_tick ? SHIFT : SETUP;
      SHIFT:   state_n = fall_tick && last_bit ? HOLD : SHIFT;
      HOLD:    state_n = rise_tick ? GAP : HOLD;
      GAP:     state_n = gap_done ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  // shift datapath: MOSI advances on falling edges, MISO captured on rising edges
  always_ff @(posedge Clk)
    if (Rst) begin
      frame <= '0;
      wr <= 1'b0;
      bit_cnt <= '0;
      shreg <= '0;
      gap_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else begin
      rsp_valid <= hold_done && !wr;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (start) begin
        frame <= al_active ? al_frame : req_frame;
        wr <= al_active || bus.Req_Write;
        bit_cnt <= '0;
      end else if (state == SHIFT && fall_tick && !last_bit) begin
        frame <= {frame[FRAME_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (rise_tick && state != HOLD) shreg <= {shreg[DATA_W-2:0], bus.MISO};
      if (hold_done && !wr) rsp_data <= shreg;
    end
endmodule

// File: tb/tb_spi_coef_master.sv
// tb_spi_coef_master: scoreboard bench with SPI responder model; COEF_AUTOLOAD_EN enables autoload checks
module tb_spi_coef_master;
  import filter_pkg::*;
  localparam int RDY_LIM = 3600;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  spi_coef_master_if bus();
  spi_coef_master_if bus2();
  spi_coef_master #(.CLK_DIV(4), .CS_GAP(4), .NUM_TAPS(16)) u_dut (.Clk(clk), .Rst(rst), .bus(bus.master));
  spi_coef_master #(.CLK_DIV(2), .CS_GAP(4), .NUM_TAPS(16)) u_dut2 (.Clk(clk), .Rst(rst), .bus(bus2.master));
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [FRAME_W-1:0] exp_q[$];
  logic [DATA_W-1:0] rsp_q[$];
  logic [DATA_W-1:0] regs [256];
  logic pcs = 1'b1, psck = 1'b0, pmosi = 1'b0;
  logic [FRAME_W-1:0] rx = '0;
  logic [DATA_W-1:0] rdv = '0;
  int nb = 0, cs_low = 0, frames = 0, n_rsp = 0, t_rise = 0, t_fall = 0, t_gap = 0, t_rsp = 0;
  bit abort = 1'b0;
  logic pc2 = 1'b1, ps2 = 1'b0, pm2 = 1'b0;
  logic [FRAME_W-1:0] r2 = '0, exp2 = '0;
  int run2 = 0, rises2 = 0, frames2 = 0;
  bit check2_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI responder and frame scoreboard for the CLK_DIV=4 instance
  initial begin : mon
    bus.MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (pcs && !bus.CS) begin
        rx = '0;
        nb = 0;
        cs_low = 0;
        t_gap = cyc - t_rise;
        t_fall = cyc;
      end
      if (bus.CS) check("idle_pins", {bus.SCK, bus.MOSI}, 0);
      else begin
        cs_low++;
        if (!psck && bus.SCK) begin
          check("mosi_stable", bus.MOSI, pmosi);
          rx = {rx[FRAME_W-2:0], bus.MOSI};
          nb++;
        end
        if (psck && !bus.SCK) begin
          if (nb == 12) rdv = regs[rx[7:0]];
          if (nb >= 12 && nb <= 23 && !rx[nb-1]) bus.MISO = rdv[23-nb];
        end
      end
      if (!pcs && bus.CS) begin
        t_rise = cyc;
        frames++;
        bus.MISO = 1'b0;
        if (abort) begin
          abort = 1'b0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          check("frame_bits", nb, 24);
          check("cs_low_cycles", cs_low, 196);
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("frame_value", rx, exp_q.pop_front());
          if (rx[23]) regs[rx[19:12]] = rx[11:0];
        end
      end
      if (bus.Rsp_Valid) begin
        n_rsp++;
        t_rsp = cyc;
        check("rsp_at_cs_rise", !pcs && bus.CS, 1);
        check("rsp_expected", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) check("rsp_data", bus.Rsp_Data, rsp_q.pop_front());
      end
      pcs = bus.CS;
      psck = bus.SCK;
      pmosi = bus.MOSI;
    end
  end

  // SCK phase and edge-count monitor for the CLK_DIV=2 instance
  initial begin : mon2
    bus2.MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus2.CS && !pc2) begin
        if (bus2.SCK != ps2) begin
          check("sck2_phase", run2, 2);
          run2 = 1;
        end else run2++;
        if (bus2.SCK && !ps2) begin
          rises2++;
          check("mosi2_stable", bus2.MOSI, pm2);
          r2 = {r2[FRAME_W-2:0], bus2.MOSI};
        end
      end
      if (pc2 && !bus2.CS) begin
        run2 = 1;
        rises2 = 0;
      end
      if (!pc2 && bus2.CS) begin
        frames2++;
        check("sck2_rises", rises2, 24);
        if (check2_en) check("frame2_value", r2, exp2);
      end
      pc2 = bus2.CS;
      ps2 = bus2.SCK;
      pm2 = bus2.MOSI;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, vectors %0d", n_vec);
    $fatal(1);
  end

  task automatic wait_ready(input int lim);
    int w = 0;
    while (!bus.Req_Ready && w < lim) begin
      @(negedge clk);
      w++;
    end
    check("ready_timeout", bus.Req_Ready, 1);
  endtask

  task automatic send(input logic w, input logic [7:0] a, input logic [11:0] d, output int t0);
    wait_ready(RDY_LIM);
    bus.Req_Valid = 1'b1;
    bus.Req_Write = w;
    bus.Req_Addr = a;
    bus.Req_Data = d;
    exp_q.push_back({w, 3'b000, a, w ? d : 12'h000});
    t0 = cyc;
    @(negedge clk);
    bus.Req_Valid = 1'b0;
    bus.Req_Addr = 8'($urandom);
    bus.Req_Data = 12'($urandom);
  endtask

  task automatic push_autoload();
`ifdef COEF_AUTOLOAD_EN
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 3'b000, 8'(i), COEF_INIT[i]});
`endif
  endtask

  initial begin : stim
    int t0, t1, f0, r0, k;
    bus.Req_Valid = 1'b0;
    bus.Req_Write = 1'b0;
    bus.Req_Addr = '0;
    bus.Req_Data = '0;
    bus2.Req_Valid = 1'b0;
    bus2.Req_Write = 1'b0;
    bus2.Req_Addr = '0;
    bus2.Req_Data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.Req_Ready, 0);
    check("rst_rsp_valid", bus.Rsp_Valid, 0);
    check("rst_rsp_data", bus.Rsp_Data, 0);
    check("rst_pins", {bus.SCK, bus.CS, bus.MOSI}, 3'b010);
`ifndef COEF_AUTOLOAD_EN
    check("rst_busy", bus.Busy, 0);
`endif
    push_autoload();
    rst = 1'b0;
    r0 = cyc;
    @(negedge clk);
`ifdef COEF_AUTOLOAD_EN
    check("al_ready_low", bus.Req_Ready, 0);
    check("al_busy", bus.Busy, 1);
    wait_ready(RDY_LIM);
    check("al_ready_time", cyc - r0, 16 * 201);
    check("al_frames", frames, 16);
    for (int i = 0; i < 16; i++) check("al_regfile", regs[i], COEF_INIT[i]);
    check("al_queue_empty", exp_q.size(), 0);
`else
    check("ready_after_rst", bus.Req_Ready, 1);
`endif
    f0 = frames;
    send(1'b1, 8'h05, 12'hABC, t0);
    wait_ready(RDY_LIM);
    check("wr_ready_cycle", cyc - t0, 201);
    check("wr_cs_fall_cycle", t_fall - t0, 1);
    check("wr_cs_rise_cycle", t_rise - t0, 197);
    check("wr_frames", frames - f0, 1);
    check("wr_no_rsp", n_rsp, 0);
    regs[3] = 12'h5A5;
    rsp_q.push_back(12'h5A5);
    send(1'b0, 8'h03, 12'hFFF, t0);
    wait_ready(RDY_LIM);
    check("rd_rsp_count", n_rsp, 1);
    check("rd_rsp_cycle", t_rsp - t0, 197);
    check("rd_queue_empty", exp_q.size() + rsp_q.size(), 0);
    f0 = frames;
    bus.Req_Valid = 1'b1;
    bus.Req_Write = 1'b1;
    bus.Req_Addr = 8'h10;
    bus.Req_Data = 12'h111;
    exp_q.push_back(24'h810111);
    t0 = cyc;
    @(negedge clk);
    bus.Req_Addr = 8'h11;
    bus.Req_Data = 12'h222;
    exp_q.push_back(24'h811222);
    wait_ready(RDY_LIM);
    t1 = cyc;
    @(negedge clk);
    bus.Req_Valid = 1'b0;
    wait_ready(RDY_LIM);
    check("b2b_second_start", t1 - t0, 201);
    check("b2b_cs_gap", t_gap, 5);
    check("b2b_frames", frames - f0, 2);
    check("b2b_queue_empty", exp_q.size(), 0);
    check("rsp_data_hold", bus.Rsp_Data, 12'h5A5);
    regs[9] = 12'h777;
    rsp_q.push_back(12'h777);
    send(1'b0, 8'h09, 12'h000, t0);
    k = 0;
    while (nb < 11 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rise10_timeout", nb, 11);
    abort = 1'b1;
    rst = 1'b1;
    void'(rsp_q.pop_front());
    push_autoload();
    @(negedge clk);
    check("midrst_pins", {bus.SCK, bus.CS, bus.MOSI}, 3'b010);
    check("midrst_rsp_valid", bus.Rsp_Valid, 0);
    check("midrst_ready", bus.Req_Ready, 0);
    rst = 1'b0;
    wait_ready(RDY_LIM);
    check("midrst_no_rsp", n_rsp, 1);
    f0 = frames;
    send(1'b1, 8'h22, 12'h456, t0);
    wait_ready(RDY_LIM);
    check("post_rst_frames", frames - f0, 1);
    check("post_rst_queue", exp_q.size(), 0);
    check("post_rst_regfile", regs[8'h22], 12'h456);
    k = 0;
    while (!bus2.Req_Ready && k < RDY_LIM) begin
      @(negedge clk);
      k++;
    end
    check("dut2_ready", bus2.Req_Ready, 1);
    f0 = frames2;
    exp2 = {1'b1, 3'b000, 8'h7E, 12'h3C5};
    check2_en = 1'b1;
    bus2.Req_Valid = 1'b1;
    bus2.Req_Write = 1'b1;
    bus2.Req_Addr = 8'h7E;
    bus2.Req_Data = 12'h3C5;
    @(negedge clk);
    bus2.Req_Valid = 1'b0;
    k = 0;
    while (!bus2.Req_Ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("dut2_frames", frames2 - f0, 1);
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
